divu_control: RTL
=================

# divu_control

Sequential unsigned 32-bit divider, the inverse companion of the shift-add multiplier control in the ALU's multi-cycle unit. It uses restoring shift-subtract division and retires one quotient bit per clock. It accepts a start strobe, iterates 32 cycles, then presents quotient and remainder with a one-cycle completion pulse. It sits beside the multiplier and shares the same start/done handshake style, so the ALU sequencer can drive both identically.

## Interface
Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH. The counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  synchronous, active-high; returns block to IDLE and clears all registers
- doDiv  input  1  start strobe; sampled only in IDLE
- dividend  input  WIDTH  numerator, sampled on the edge that accepts doDiv
- divisor  input  WIDTH  denominator, sampled on the same edge
- quotient  output  WIDTH  registered result; reset 0
- remainder  output  WIDTH  registered result; reset 0
- busy  output  1  high while iterating; reset 0
- div_done  output  1  one-cycle completion pulse; reset 0
- div_zero  output  1  divisor was 0 on the last accepted op; reset 0; held with results

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- IDLE, doDiv=1, divisor≠0: load Q←dividend, D←divisor, R←0, cnt←0; clear div_zero; go to RUN.
- IDLE, doDiv=1, divisor=0: set quotient←all ones, remainder←dividend, div_zero←1; go to DONE with no iterations.
- IDLE, doDiv=0: hold all outputs.
- RUN, each cycle:
  - Form R' = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - Compute trial = {1'b0,R'} − {1'b0,D}, WIDTH+1 bits.
  - If trial[WIDTH]=0 (no borrow): R←trial[WIDTH-1:0], Q←{Q[WIDTH-2:0],1}.
  - Otherwise: R←R', Q←{Q[WIDTH-2:0],0}.
  - cnt←cnt+1.
- RUN exit: when cnt=WIDTH-1 at the edge, that edge performs the final iteration, copies the final Q/R into quotient/remainder, and moves to DONE.
- DONE: div_done=1 for exactly one cycle, then unconditionally back to IDLE. doDiv is ignored in DONE.
- doDiv in RUN or DONE is ignored. It is not queued.
- quotient and remainder change only on entry to DONE. Intermediate Q/R never appear on the outputs.
- The subtractor must be WIDTH+1 bits so a remainder ≥ 2^(WIDTH-1) is handled without overflow.

## Timing
- Edge 0 accepts doDiv (IDLE→RUN).
- busy=1 from cycle 1 through cycle WIDTH (32 cycles).
- Results become valid and div_done=1 in cycle WIDTH+1 (33 for WIDTH=32); busy=0 in that cycle.
- IDLE from cycle WIDTH+2; a new doDiv is accepted there at the earliest.
- Divide-by-zero: div_done=1 in cycle 1, busy never asserts, IDLE in cycle 2.
- Reset asserted in any cycle, including mid-RUN or DONE: on the next edge state=IDLE and all outputs and internal registers are 0. An aborted operation produces no div_done.
- doDiv held high continuously starts a new op each time IDLE is reached, i.e. every WIDTH+2 cycles.

## Test plan
- 100 / 7 → div_done in cycle 33, quotient=14, remainder=2, div_zero=0; busy high in exactly cycles 1–32.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0. Then 0xFFFFFFFF / 0x80000000 → quotient=1, remainder=0x7FFFFFFF (exercises the WIDTH+1 subtract).
- 5 / 0 → div_done in cycle 1, quotient=0xFFFFFFFF, remainder=5, div_zero=1, busy never high. A following 9/3 clears div_zero and gives quotient=3, remainder=0.
- 3 / 10 → quotient=0, remainder=3. Outputs hold these values for 20 idle cycles afterward.
- Start 1000/3, pulse doDiv again at cycle 10 with 50/5 → the second request is ignored; result is quotient=333, remainder=1 in cycle 33.
- Start 1000/3, assert reset at cycle 12 → next cycle busy=0 and all outputs 0, no div_done. Then 81/9 → quotient=9, remainder=0 in cycle 33 of the new op.

Source files
------------

// File: rtl/divu_control.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations,
// start/done handshake matching the shift-add multiplier control.
module divu_control #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             doDiv,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             div_done,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  d_q;
    logic [WIDTH-1:0]  r_q;
    logic [CntW-1:0]   cnt_q;

    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_next;
    logic [WIDTH-1:0]  q_next;
    logic [WIDTH:0]    trial;
    logic              last_iter;

    // Extra top bit on the subtract acts as the borrow, so R' >= 2^(WIDTH-1) cannot overflow.
    always_comb begin
        r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        trial   = {1'b0, r_shift} - {1'b0, d_q};
        r_next  = r_shift;
        q_next  = {q_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            q_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            div_done  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (doDiv) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            div_done  <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            q_q      <= dividend;
                            d_q      <= divisor;
                            r_q      <= '0;
                            cnt_q    <= '0;
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                end
                StRun: begin
                    q_q   <= q_next;
                    r_q   <= r_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        busy      <= 1'b0;
                        div_done  <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    div_done <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
